dilithium_out_downsizer: RTL

//  Buffers and narrows the 64-bit result stream (valid/ready/data/last) of the high-performance

---
 rtl/dilithium_out_downsizer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dilithium_out_downsizer.sv
// dilithium_out_downsizer
//   Buffers the 64-bit result stream of the Dilithium core in a small FIFO and
//   emits each buffered beat as two 32-bit words for the host bus. It also
//   keeps a per-frame word counter and a frame_done pulse for the host status
//   register.
//   Optional feature: define DILITHIUM_DOWNSIZER_TRIM_EN to add s_last_half.
//   A final beat flagged with it is shortened to its first-emitted half.
//   Reset rst is asynchronous and active-low.
module dilithium_out_downsizer #(
  parameter int DEPTH     = 4,   // FIFO entries; power of two, >= 2
  parameter bit LOW_FIRST = 1'b1 // 1: bits[31:0] leave first
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic        s_last,
`ifdef DILITHIUM_DOWNSIZER_TRIM_EN
  input  logic        s_last_half,
`endif
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic [15:0] words_out,
  output logic        frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Entry storage; it is not reset because occupancy is tracked by count_q.
  logic [63:0]   mem_data [DEPTH];
  logic          mem_last [DEPTH];
`ifdef DILITHIUM_DOWNSIZER_TRIM_EN
  logic          mem_half [DEPTH];
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          sel_q,    sel_d;
  logic          ready_en_q;      // keeps s_ready low until the first edge after reset
  logic [15:0]   words_q,  words_d;
  logic          done_q,   done_d;
  logic [31:0]   hold_q;          // last word shown; presented while the FIFO is empty

  logic          push;
  logic          pop_hs;
  logic          free;
  logic [63:0]   cur_entry;
  logic          cur_last;
  logic          cur_trim;
  logic [31:0]   first_half;
  logic [31:0]   second_half;
  logic [31:0]   cur_word;

  assign cur_entry   = mem_data[rd_ptr_q];
  assign cur_last    = mem_last[rd_ptr_q];
`ifdef DILITHIUM_DOWNSIZER_TRIM_EN
  assign cur_trim    = cur_last && mem_half[rd_ptr_q];
`else
  assign cur_trim    = 1'b0;
`endif
  assign first_half  = LOW_FIRST ? cur_entry[31:0]  : cur_entry[63:32];
  assign second_half = LOW_FIRST ? cur_entry[63:32] : cur_entry[31:0];
  assign cur_word    = sel_q ? second_half : first_half;

  // s_ready depends on registered occupancy only, so a full FIFO never admits a push.
  assign s_ready    = ready_en_q && (count_q != FULL);
  assign push       = s_valid && s_ready;
  assign m_valid    = (count_q != '0);
  assign pop_hs     = m_valid && m_ready;
  // An entry is freed after its second word, or after its only word when trimmed.
  assign free       = pop_hs && (sel_q || cur_trim);
  assign m_data     = m_valid ? cur_word : hold_q;
  assign m_last     = m_valid && cur_last && (sel_q || cur_trim);
  assign words_out  = words_q;
  assign frame_done = done_q;

  // Write the accepted beat into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= s_data;
      mem_last[wr_ptr_q] <= s_last;
`ifdef DILITHIUM_DOWNSIZER_TRIM_EN
      mem_half[wr_ptr_q] <= s_last_half;
`endif
    end
  end

  // Next-state for pointers, occupancy, half select and frame status.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sel_d    = sel_q;
    words_d  = done_q ? 16'd0 : words_q;
    done_d   = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (free) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, free})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (pop_hs) begin
      // Low select moves to the second half unless the entry is trimmed.
      sel_d  = !sel_q && !cur_trim;
      done_d = m_last;
      if (words_d != 16'hFFFF) begin
        words_d = words_d + 16'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sel_q      <= 1'b0;
      ready_en_q <= 1'b0;
      words_q    <= 16'd0;
      done_q     <= 1'b0;
      hold_q     <= 32'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sel_q      <= sel_d;
      ready_en_q <= 1'b1;
      words_q    <= words_d;
      done_q     <= done_d;
      if (m_valid) begin
        hold_q <= cur_word;
      end
    end
  end

endmodule
